pr_resp_receiver: RTL and testbench



---
 rtl/pr_resp_receiver.sv | 132 +++++++++++++
 tb/tb_pr_resp_receiver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pr_resp_receiver.sv
// Response-side endpoint of the 21-bit response NoC for one pagerank quadrant.
// Issued requests are tagged with a per-destination sequence number. The requested
// node ID is held in a 4x8 outstanding scoreboard. Returning packets are matched
// against the scoreboard and queued in a small FIFO for the local compute engine.
module pr_resp_receiver #(
    parameter int WIDTH      = 16,
    parameter int NID_W      = 6,
    parameter int SEQ_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iss_valid,
    input  logic [1:0]         iss_quad,
    input  logic [NID_W-1:0]   iss_node,
    output logic               iss_ready,
    output logic [SEQ_W-1:0]   iss_seq,
    input  logic [WIDTH+4:0]   pkt_in,
    input  logic               pkt_write,
    output logic               val_valid,
    output logic [NID_W-1:0]   val_node,
    output logic [WIDTH-1:0]   val_value,
    input  logic               val_ready,
    output logic [5:0]         outstanding,
    output logic               idle,
    output logic               err_unsolicited,
    output logic               err_overflow
);

    localparam int SLOTS = 1 << SEQ_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Scoreboard: valid bits and the per-quad tag counters are control state.
    // Node IDs are data and need no reset.
    logic [3:0][SLOTS-1:0] slotValid;
    logic [3:0][SEQ_W-1:0] nextSeq;
    logic [NID_W-1:0]      slotNode [4][SLOTS];

    // Matched-value FIFO
    logic [NID_W-1:0]      fifoNode [FIFO_DEPTH];
    logic [WIDTH-1:0]      fifoVal  [FIFO_DEPTH];
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic [CNT_W-1:0]      count;

    logic [5:0]            outstandingCnt;
    logic                  errUnsol;
    logic                  errOvf;

    // Response packet fields
    logic [1:0]            pktQuad;
    logic [SEQ_W-1:0]      pktSeq;
    logic [WIDTH-1:0]      pktVal;

    logic                  issueFire;
    logic                  slotHit;
    logic                  pop;
    logic                  canPush;
    logic                  push;

    assign pktQuad = pkt_in[WIDTH+4:WIDTH+3];
    assign pktSeq  = pkt_in[WIDTH+2:WIDTH];
    assign pktVal  = pkt_in[WIDTH-1:0];

    // Readiness depends only on registered scoreboard state. Because of this,
    // an issue can never target the slot that a response frees in the same cycle.
    assign iss_seq   = nextSeq[iss_quad];
    assign iss_ready = ~slotValid[iss_quad][nextSeq[iss_quad]];
    assign issueFire = iss_valid & iss_ready;

    assign val_valid = (count != '0);
    assign pop       = val_valid & val_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign canPush   = (count < FULL_CNT) | pop;
    assign slotHit   = pkt_write & slotValid[pktQuad][pktSeq];
    assign push      = slotHit & canPush;

    assign val_node        = fifoNode[rdPtr];
    assign val_value       = fifoVal[rdPtr];
    assign outstanding     = outstandingCnt;
    assign idle            = (outstandingCnt == '0) && (count == '0);
    assign err_unsolicited = errUnsol;
    assign err_overflow    = errOvf;

    // Control state: slot valid bits, tag counters, FIFO pointers, counts, and sticky errors
    always_ff @(posedge clk) begin
        if (reset) begin
            slotValid      <= '0;
            nextSeq        <= '0;
            wrPtr          <= '0;
            rdPtr          <= '0;
            count          <= '0;
            outstandingCnt <= '0;
            errUnsol       <= 1'b0;
            errOvf         <= 1'b0;
        end else begin
            if (push) begin
                slotValid[pktQuad][pktSeq] <= 1'b0;
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (issueFire) begin
                slotValid[iss_quad][nextSeq[iss_quad]] <= 1'b1;
                nextSeq[iss_quad] <= nextSeq[iss_quad] + SEQ_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count          <= count + CNT_W'(push) - CNT_W'(pop);
            outstandingCnt <= outstandingCnt + 6'(issueFire) - 6'(push);
            if (pkt_write && !slotValid[pktQuad][pktSeq]) begin
                errUnsol <= 1'b1;
            end
            if (slotHit && !canPush) begin
                errOvf <= 1'b1;
            end
        end
    end

    // Data storage: requested node IDs and FIFO entries, written without reset
    always_ff @(posedge clk) begin
        if (issueFire) begin
            slotNode[iss_quad][nextSeq[iss_quad]] <= iss_node;
        end
        if (push) begin
            fifoNode[wrPtr] <= slotNode[pktQuad][pktSeq];
            fifoVal[wrPtr]  <= pktVal;
        end
    end

endmodule

// File: tb/tb_pr_resp_receiver.sv
// Directed-vector bench for pr_resp_receiver. The stimulus pushes hand-computed
// {node, value} expectations. A negedge monitor pops and compares them on every
// accepted output.
module tb_pr_resp_receiver;

    localparam int WIDTH = 16;
    localparam int NID_W = 6;
    localparam int SEQ_W = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               iss_valid;
    logic [1:0]         iss_quad;
    logic [NID_W-1:0]   iss_node;
    logic               iss_ready;
    logic [SEQ_W-1:0]   iss_seq;
    logic [WIDTH+4:0]   pkt_in;
    logic               pkt_write;
    logic               val_valid;
    logic [NID_W-1:0]   val_node;
    logic [WIDTH-1:0]   val_value;
    logic               val_ready;
    logic [5:0]         outstanding;
    logic               idle;
    logic               err_unsolicited;
    logic               err_overflow;

    int passCount  = 0;
    int totalCount = 0;
    logic [NID_W+WIDTH-1:0] expQ[$];

    pr_resp_receiver #(.WIDTH(WIDTH), .NID_W(NID_W), .SEQ_W(SEQ_W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_quad(iss_quad), .iss_node(iss_node),
        .iss_ready(iss_ready), .iss_seq(iss_seq),
        .pkt_in(pkt_in), .pkt_write(pkt_write),
        .val_valid(val_valid), .val_node(val_node), .val_value(val_value),
        .val_ready(val_ready),
        .outstanding(outstanding), .idle(idle),
        .err_unsolicited(err_unsolicited), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [NID_W-1:0] node, input logic [WIDTH-1:0] value);
        expQ.push_back({node, value});
    endtask

    // One issue cycle; checks the handshake outputs before the edge.
    task automatic issue(input logic [1:0] quad, input logic [NID_W-1:0] node,
                         input logic [SEQ_W-1:0] expSeq);
        iss_valid = 1'b1;
        iss_quad  = quad;
        iss_node  = node;
        #1;
        chk("iss_ready", 32'(iss_ready), 32'd1);
        chk("iss_seq", 32'(iss_seq), 32'(expSeq));
        tick();
        iss_valid = 1'b0;
    endtask

    task automatic resp(input logic [1:0] quad, input logic [SEQ_W-1:0] seq,
                        input logic [WIDTH-1:0] value);
        pkt_in    = {quad, seq, value};
        pkt_write = 1'b1;
        tick();
        pkt_write = 1'b0;
    endtask

    // Monitor: every accepted output must match the oldest expectation.
    always @(negedge clk) begin
        if (val_valid && val_ready) begin
            if (expQ.size() == 0) begin
                chk("unexpected_output", {10'd0, val_node, val_value}, 32'hFFFF_FFFF);
            end else begin
                logic [NID_W+WIDTH-1:0] e;
                e = expQ.pop_front();
                chk("out_node_value", {10'd0, val_node, val_value}, {10'd0, e});
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; iss_valid = 1'b0; iss_quad = 2'd0; iss_node = '0;
        pkt_in = '0; pkt_write = 1'b0; val_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        // Reset state
        chk("rst_val_valid", 32'(val_valid), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_err_unsol", 32'(err_unsolicited), 32'd0);
        chk("rst_err_ovf", 32'(err_overflow), 32'd0);
        chk("rst_iss_ready", 32'(iss_ready), 32'd1);
        chk("rst_iss_seq", 32'(iss_seq), 32'd0);

        // Single request/response with one-cycle latency
        issue(2'd1, 6'd20, 3'd0);
        chk("t1_outstanding", 32'(outstanding), 32'd1);
        chk("t1_idle", 32'(idle), 32'd0);
        iss_quad = 2'd1; #1;
        chk("t1_next_seq", 32'(iss_seq), 32'd1);
        expect_out(6'd20, 16'h1234);
        pkt_in = {2'd1, 3'd0, 16'h1234}; pkt_write = 1'b1; #1;
        chk("t1_no_comb_path", 32'(val_valid), 32'd0);
        tick(); pkt_write = 1'b0;
        chk("t1_val_valid", 32'(val_valid), 32'd1);
        chk("t1_val_node", 32'(val_node), 32'd20);
        chk("t1_out_after", 32'(outstanding), 32'd0);
        tick();
        chk("t1_idle_after", 32'(idle), 32'd1);

        // Fill all eight quad-2 slots
        for (int i = 0; i < 8; i++) issue(2'd2, 6'(30 + i), 3'(i));
        chk("t2_outstanding8", 32'(outstanding), 32'd8);
        iss_valid = 1'b1; iss_quad = 2'd2; iss_node = 6'd63; #1;
        chk("t2_ready_full", 32'(iss_ready), 32'd0);
        tick(); iss_valid = 1'b0;
        chk("t2_no_issue_state", 32'(outstanding), 32'd8);
        expect_out(6'd33, 16'h0303);
        resp(2'd2, 3'd3, 16'h0303);
        iss_quad = 2'd2; #1;
        chk("t2_ready_still0", 32'(iss_ready), 32'd0);
        expect_out(6'd30, 16'h0300);
        resp(2'd2, 3'd0, 16'h0300);
        iss_quad = 2'd2; #1;
        chk("t2_ready_back", 32'(iss_ready), 32'd1);
        chk("t2_seq_back", 32'(iss_seq), 32'd0);
        chk("t2_outstanding6", 32'(outstanding), 32'd6);
        for (int s = 1; s < 8; s++) begin
            if (s != 3) begin
                expect_out(6'(30 + s), 16'(16'h0300 + s));
                resp(2'd2, 3'(s), 16'(16'h0300 + s));
            end
        end
        tick();
        chk("t2_drained", 32'(outstanding), 32'd0);

        // Out-of-order responses on quad 3
        issue(2'd3, 6'd48, 3'd0);
        issue(2'd3, 6'd49, 3'd1);
        issue(2'd3, 6'd50, 3'd2);
        expect_out(6'd50, 16'hA002); resp(2'd3, 3'd2, 16'hA002);
        expect_out(6'd48, 16'hA000); resp(2'd3, 3'd0, 16'hA000);
        expect_out(6'd49, 16'hA001); resp(2'd3, 3'd1, 16'hA001);
        tick(); tick();

        // Unsolicited packet
        resp(2'd0, 3'd5, 16'hDEAD);
        chk("t4_err_unsol", 32'(err_unsolicited), 32'd1);
        chk("t4_val_valid", 32'(val_valid), 32'd0);
        chk("t4_outstanding", 32'(outstanding), 32'd0);

        // FIFO full: same-cycle pop+push accepted, then overflow drop
        val_ready = 1'b0;
        for (int i = 0; i < 6; i++) issue(2'd0, 6'(1 + i), 3'(i));
        for (int s = 0; s < 4; s++) begin
            expect_out(6'(1 + s), 16'(16'hB000 + s));
            resp(2'd0, 3'(s), 16'(16'hB000 + s));
        end
        chk("t5_full_no_ovf", 32'(err_overflow), 32'd0);
        val_ready = 1'b1;
        expect_out(6'd5, 16'hB004);
        resp(2'd0, 3'd4, 16'hB004);
        val_ready = 1'b0;
        chk("t5_poppush_no_ovf", 32'(err_overflow), 32'd0);
        chk("t5_outstanding1", 32'(outstanding), 32'd1);
        resp(2'd0, 3'd5, 16'hBBBB);
        chk("t5_err_ovf", 32'(err_overflow), 32'd1);
        chk("t5_slot_live", 32'(outstanding), 32'd1);
        chk("t5_val_valid", 32'(val_valid), 32'd1);
        val_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        expect_out(6'd6, 16'hB005);
        resp(2'd0, 3'd5, 16'hB005);
        tick();
        chk("t5_outstanding0", 32'(outstanding), 32'd0);
        chk("t5_idle", 32'(idle), 32'd1);

        // Reset mid-operation: 3 outstanding, 2 buffered
        val_ready = 1'b0;
        for (int i = 0; i < 5; i++) issue(2'd1, 6'(10 + i), 3'(1 + i));
        resp(2'd1, 3'd1, 16'hC001);
        resp(2'd1, 3'd2, 16'hC002);
        chk("t6_pre_outstanding", 32'(outstanding), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        iss_quad = 2'd1; #1;
        chk("t6_idle", 32'(idle), 32'd1);
        chk("t6_val_valid", 32'(val_valid), 32'd0);
        chk("t6_err_ovf_cleared", 32'(err_overflow), 32'd0);
        chk("t6_err_unsol_cleared", 32'(err_unsolicited), 32'd0);
        chk("t6_iss_seq", 32'(iss_seq), 32'd0);
        val_ready = 1'b1;
        resp(2'd1, 3'd3, 16'hC003);
        chk("t6_old_tag_unsol", 32'(err_unsolicited), 32'd1);
        chk("t6_no_output", 32'(val_valid), 32'd0);

        tick(); tick();
        chk("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
